// File: rtl/conv_out_col2im_stream_if.sv
// Stream bundle for the col2im drain stage: GEMM rows in, CHW feature-map elements out.
interface conv_out_col2im_stream_if #(
  parameter int DATA_W_P = 8,
  parameter int ACC_W_P  = 32,
  parameter int COUT     = 4,
  parameter int H_OUT    = 8,
  parameter int W_OUT    = 8
);
  localparam int CO_W = (COUT  > 1) ? $clog2(COUT)  : 1;
  localparam int OH_W = (H_OUT > 1) ? $clog2(H_OUT) : 1;
  localparam int OW_W = (W_OUT > 1) ? $clog2(W_OUT) : 1;

  logic                       in_valid;
  logic                       in_ready;
  logic signed [ACC_W_P-1:0]  in_data [COUT];
  logic                       out_valid;
  logic                       out_ready;
  logic signed [DATA_W_P-1:0] out_data;
  logic [CO_W-1:0]            out_co;
  logic [OH_W-1:0]            out_oh;
  logic [OW_W-1:0]            out_ow;
  logic                       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_co, out_oh, out_ow, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_co, out_oh, out_ow, out_last
  );
endinterface

// File: rtl/conv_out_col2im_stream.sv
// Requantizes GEMM result rows into a frame buffer, then streams the frame out
// one element per beat in CHW raster order for the next conv layer.
module conv_out_col2im_stream #(
  parameter int DATA_W_P = 8,
  parameter int ACC_W_P  = 32,
  parameter int COUT     = 4,
  parameter int H_OUT    = 8,
  parameter int W_OUT    = 8,
  parameter int SHIFT    = 4,
  parameter int RELU_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  conv_out_col2im_stream_if.slave bus
);
  localparam int M_TOTAL = H_OUT * W_OUT;
  localparam int CO_W = (COUT    > 1) ? $clog2(COUT)    : 1;
  localparam int OH_W = (H_OUT   > 1) ? $clog2(H_OUT)   : 1;
  localparam int OW_W = (W_OUT   > 1) ? $clog2(W_OUT)   : 1;
  localparam int M_W  = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1;

  localparam logic signed [ACC_W_P-1:0] SAT_MAX =
    {{(ACC_W_P-DATA_W_P+1){1'b0}}, {(DATA_W_P-1){1'b1}}};
  localparam logic signed [ACC_W_P-1:0] SAT_MIN =
    {{(ACC_W_P-DATA_W_P+1){1'b1}}, {(DATA_W_P-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                     state;
  logic [M_W-1:0]             wr_m;
  logic [M_W-1:0]             pix;
  logic signed [DATA_W_P-1:0] frame_buf [COUT][M_TOTAL];
  logic signed [ACC_W_P-1:0]  shifted [COUT];
  logic signed [DATA_W_P-1:0] q [COUT];
  logic                       in_fire;
  logic                       out_fire;
  logic [CO_W-1:0]            nxt_co;
  logic [OH_W-1:0]            nxt_oh;
  logic [OW_W-1:0]            nxt_ow;
  logic [M_W-1:0]             nxt_pix;
  logic                       nxt_last;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Shift, optional ReLU, then saturate each accumulator into the stored width.
  always_comb begin
    for (int n = 0; n < COUT; n++) begin
      shifted[n] = bus.in_data[n] >>> SHIFT;
      if (RELU_EN != 0 && shifted[n][ACC_W_P-1])
        shifted[n] = '0;
      if (shifted[n] > SAT_MAX)
        q[n] = SAT_MAX[DATA_W_P-1:0];
      else if (shifted[n] < SAT_MIN)
        q[n] = SAT_MIN[DATA_W_P-1:0];
      else
        q[n] = shifted[n][DATA_W_P-1:0];
    end
  end

  always_comb begin
    nxt_ow = bus.out_ow + 1'b1;
    nxt_oh = bus.out_oh;
    nxt_co = bus.out_co;
    if (bus.out_ow == OW_W'(W_OUT-1)) begin
      nxt_ow = '0;
      nxt_oh = bus.out_oh + 1'b1;
      if (bus.out_oh == OH_W'(H_OUT-1)) begin
        nxt_oh = '0;
        nxt_co = bus.out_co + 1'b1;
      end
    end
    nxt_pix  = (pix == M_W'(M_TOTAL-1)) ? '0 : pix + 1'b1;
    nxt_last = (nxt_co == CO_W'(COUT-1)) && (nxt_pix == M_W'(M_TOTAL-1));
  end

  // The buffer is deliberately left out of reset; it is always fully rewritten before a drain.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int n = 0; n < COUT; n++)
        frame_buf[n][wr_m] <= q[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_m          <= '0;
      pix           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.out_co    <= '0;
      bus.out_oh    <= '0;
      bus.out_ow    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= FILL;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            wr_m         <= '0;
          end
        end
        FILL: begin
          if (in_fire) begin
            if (wr_m == M_W'(M_TOTAL-1)) begin
              // A one-pixel frame has its only row arriving on this very edge, so bypass the buffer.
              state         <= DRAIN;
              wr_m          <= '0;
              pix           <= '0;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_data  <= (M_TOTAL == 1) ? q[0] : frame_buf[0][0];
              bus.out_co    <= '0;
              bus.out_oh    <= '0;
              bus.out_ow    <= '0;
              bus.out_last  <= (COUT * M_TOTAL == 1);
            end else begin
              wr_m <= wr_m + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (bus.out_last) begin
              state         <= IDLE;
              busy          <= 1'b0;
              done          <= 1'b1;
              pix           <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.out_co    <= '0;
              bus.out_oh    <= '0;
              bus.out_ow    <= '0;
            end else begin
              pix          <= nxt_pix;
              bus.out_co   <= nxt_co;
              bus.out_oh   <= nxt_oh;
              bus.out_ow   <= nxt_ow;
              bus.out_data <= frame_buf[nxt_co][nxt_pix];
              bus.out_last <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_out_col2im_stream.sv
// Self-checking bench: two instances (ReLU off/on) share stimulus; a scoreboard
// of expected CHW beats is filled per frame and drained as the outputs handshake.
module tb_conv_out_col2im_stream;
  localparam int COUT    = 4;
  localparam int H_OUT   = 8;
  localparam int W_OUT   = 8;
  localparam int M_TOTAL = H_OUT * W_OUT;
  localparam int TOTAL   = COUT * M_TOTAL;

  typedef struct packed {
    logic signed [7:0] data;
    logic [1:0]        co;
    logic [2:0]        oh;
    logic [2:0]        ow;
    logic              last;
  } beat_t;

  typedef struct {
    logic signed [31:0] acc;
    int                 exp_norelu;
    int                 exp_relu;
  } vec_t;

  logic clk, rst, start;
  logic busy0, done0, busy1, done1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   beats0 = 0;
  int   done_count = 0;
  int   last_hs_cycle = 0;
  bit   prev_stall = 0;
  beat_t held;
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  vec_t  vec_tab [8];

  conv_out_col2im_stream_if #(.DATA_W_P(8), .ACC_W_P(32), .COUT(COUT), .H_OUT(H_OUT), .W_OUT(W_OUT)) bus0 ();
  conv_out_col2im_stream_if #(.DATA_W_P(8), .ACC_W_P(32), .COUT(COUT), .H_OUT(H_OUT), .W_OUT(W_OUT)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.out_ready = bus0.out_ready;

  conv_out_col2im_stream #(.DATA_W_P(8), .ACC_W_P(32), .COUT(COUT), .H_OUT(H_OUT), .W_OUT(W_OUT),
                           .SHIFT(4), .RELU_EN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .bus(bus0));

  conv_out_col2im_stream #(.DATA_W_P(8), .ACC_W_P(32), .COUT(COUT), .H_OUT(H_OUT), .W_OUT(W_OUT),
                           .SHIFT(4), .RELU_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic beat_t cur_beat0();
    return {bus0.out_data, bus0.out_co, bus0.out_oh, bus0.out_ow, bus0.out_last};
  endfunction

  // Scoreboard and protocol monitor for the ReLU-off instance.
  always @(negedge clk) begin
    beat_t cur, e;
    if (!rst) begin
      cur = cur_beat0();
      if (prev_stall) begin
        check_output("stall_hold", longint'(cur), longint'(held));
        check_output("stall_valid", bus0.out_valid, 1);
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q0.size() == 0) check_output("unexpected_beat", 1, 0);
        else begin
          e = exp_q0.pop_front();
          check_output("beat", longint'(cur), longint'(e));
        end
        beats0++;
        if (bus0.out_last) last_hs_cycle = cyc;
      end
      if (!bus0.out_valid) check_output("idle_outputs_zero", longint'(cur), 0);
      prev_stall = bus0.out_valid && !bus0.out_ready;
      held = cur;
      if (done0) begin
        done_count++;
        check_output("done_after_last", cyc - last_hs_cycle, 1);
      end
      if (done0 || done1) check_output("relu_done_sync", done1, done0);
    end else begin
      prev_stall = 0;
    end
  end

  always @(negedge clk) begin
    beat_t cur, e;
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      cur = {bus1.out_data, bus1.out_co, bus1.out_oh, bus1.out_ow, bus1.out_last};
      if (exp_q1.size() == 0) check_output("relu_unexpected_beat", 1, 0);
      else begin
        e = exp_q1.pop_front();
        check_output("relu_beat", longint'(cur), longint'(e));
      end
    end
  end

  function automatic logic signed [31:0] row_value(input int mode, input int m, input int n);
    if (mode == 0) return 32'((m - 32 + n) * 16);
    return vec_tab[(m * COUT + n) % 8].acc;
  endfunction

  task automatic push_expected(input int mode);
    beat_t b;
    int v0, v1, pix;
    for (int co = 0; co < COUT; co++)
      for (int oh = 0; oh < H_OUT; oh++)
        for (int ow = 0; ow < W_OUT; ow++) begin
          pix = oh * W_OUT + ow;
          if (mode == 0) begin
            v0 = pix - 32 + co;
            v1 = (v0 < 0) ? 0 : v0;
          end else begin
            v0 = vec_tab[(pix * COUT + co) % 8].exp_norelu;
            v1 = vec_tab[(pix * COUT + co) % 8].exp_relu;
          end
          b.co = 2'(co); b.oh = 3'(oh); b.ow = 3'(ow);
          b.last = (co == COUT - 1) && (pix == M_TOTAL - 1);
          b.data = 8'(v0); exp_q0.push_back(b);
          b.data = 8'(v1); exp_q1.push_back(b);
        end
  endtask

  // Entered and left at posedge+1; drives rows in order, counting real handshakes.
  task automatic apply_stimulus(input int mode, input int n_rows, input bit bubbles, input bit glitch);
    int m = 0;
    int guard = 0;
    bit accepted;
    while (m < n_rows && guard < 2000) begin
      bus0.in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int n = 0; n < COUT; n++) bus0.in_data[n] = row_value(mode, m, n);
      start = glitch && (m == 20);
      @(negedge clk);
      check_output("in_ready_fill", bus0.in_ready, 1);
      accepted = bus0.in_valid && bus0.in_ready;
      @(posedge clk); #1;
      if (accepted) m++;
      guard++;
    end
    bus0.in_valid = 1'b0;
    start = 1'b0;
    if (guard >= 2000) check_output("fill_timeout", 0, 1);
  endtask

  task automatic run_frame(input int mode, input bit bp_toggle, input bit bubbles, input bit extra_in,
                           input bit glitch, input bit pre_started, input bit chain_next);
    int start_cycle, beats_start, guard;
    bit seen;
    push_expected(mode);
    beats_start = beats0;
    if (!pre_started) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start_cycle = cyc;
    start = 1'b0;
    check_output("busy_after_start", busy0, 1);
    check_output("in_ready_after_start", bus0.in_ready, 1);
    apply_stimulus(mode, M_TOTAL, bubbles, glitch);
    check_output("in_ready_after_last_row", bus0.in_ready, 0);
    check_output("out_valid_after_last_row", bus0.out_valid, 1);
    seen = 0;
    guard = 0;
    while (!seen && guard < 3000) begin
      bus0.out_ready = bp_toggle ? ~bus0.out_ready : 1'b1;
      bus0.in_valid  = extra_in ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int n = 0; n < COUT; n++) bus0.in_data[n] = 32'($urandom);
      start = glitch && (guard == 40);
      @(negedge clk);
      if (done0) seen = 1;
      else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    start = 1'b0;
    if (!seen) check_output("drain_timeout", 0, 1);
    else begin
      check_output("frame_beats", beats0 - beats_start, TOTAL);
      check_output("busy_at_done", busy0, 0);
      check_output("out_valid_at_done", bus0.out_valid, 0);
      // start cycle + 64 fill + 256 drain, done lands 320 edges after the start edge
      if (!bp_toggle && !bubbles) check_output("frame_latency", cyc - start_cycle, 1 + M_TOTAL + TOTAL - 1);
    end
    if (chain_next) start = 1'b1;
    else begin
      @(posedge clk); #1;
      check_output("done_one_cycle", done0, 0);
    end
  endtask

  initial begin
    int dc;
    vec_tab[0] = '{32'h7FFF_FFFF, 127, 127};
    vec_tab[1] = '{-32'sd65536, -128, 0};
    vec_tab[2] = '{-32'sd1, -1, 0};
    vec_tab[3] = '{32'h0000_07F0, 127, 127};
    vec_tab[4] = '{32'h0000_0800, 127, 127};
    vec_tab[5] = '{32'sd16, 1, 1};
    vec_tab[6] = '{-32'sd32, -2, 0};
    vec_tab[7] = '{32'sd0, 0, 0};

    rst = 1'b0; start = 1'b0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    for (int n = 0; n < COUT; n++) bus0.in_data[n] = '0;
    #1 rst = 1'b1;
    #1;
    check_output("reset_busy", busy0, 0);
    check_output("reset_in_ready", bus0.in_ready, 0);
    check_output("reset_outputs", longint'(cur_beat0()), 0);
    check_output("reset_out_valid", bus0.out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] ramp frame, out_ready held high");
    run_frame(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] saturation / relu vector frame");
    run_frame(1, 0, 0, 0, 0, 0, 0);
    $display("[TB] ramp frame with output backpressure");
    run_frame(0, 1, 0, 0, 0, 0, 0);
    $display("[TB] ramp frame with input bubbles and stray in_valid in drain");
    run_frame(0, 0, 1, 1, 0, 0, 1);
    $display("[TB] start coincident with done, start glitches in fill and drain");
    run_frame(0, 0, 0, 0, 1, 1, 0);

    $display("[TB] reset after 30 rows");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    apply_stimulus(0, 30, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_output("midreset_busy", busy0, 0);
    check_output("midreset_done", done0, 0);
    check_output("midreset_in_ready", bus0.in_ready, 0);
    check_output("midreset_out_valid", bus0.out_valid, 0);
    check_output("midreset_outputs", longint'(cur_beat0()), 0);
    @(posedge clk); #1 rst = 1'b0;
    dc = done_count;
    repeat (5) @(posedge clk);
    #1;
    check_output("no_done_after_reset", done_count, dc);
    check_output("idle_after_reset", busy0, 0);
    run_frame(0, 0, 0, 0, 0, 0, 0);

    check_output("scoreboard_drained", exp_q0.size(), 0);
    check_output("relu_scoreboard_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
